// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for an RV32I subset (R/I ALU, LW, SW, BEQ).
// Owns the PC and the fetch handshake, and drives every control input of the regfile/ALU/memory datapath.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          TW       = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_ack_i,
  input  logic        zero_flag,
  input  logic        mem_ack_i,
  output logic [4:0]  read_reg_num1,
  output logic [4:0]  read_reg_num2,
  output logic [4:0]  write_reg,
  output logic [3:0]  alu_control,
  output logic        regwrite,
  output logic [31:0] immediate_value_o,
  output logic        alu_src_b_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_to_reg_o,
  output logic [31:0] pc_o,
  output logic        halted_o,
  output logic [1:0]  err_code_o
);

  // state  | meaning
  // FETCH  | request instr_addr_o until acked (only while run_i or a request is pending)
  // DECODE | register fields, immediate and ALU op from IR; illegal encodings trap
  // EXEC   | ALU cycle: R/I write back, BEQ resolves the PC, LW/SW form the address
  // MEM    | hold load/store strobes until mem_ack_i
  // TRAP   | halted with err_code_o latched; left only through reset
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_TRAP} state_t;
  typedef enum logic [2:0] {K_R, K_I, K_LW, K_SW, K_BEQ} kind_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q;
  kind_t         kind_q;
  logic [31:0]   pc_q;
  logic [31:0]   ir_q;
  logic [TW-1:0] wait_cnt;
  logic          hold_q;

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm_i;
  logic [31:0]   imm_s;
  logic [31:0]   imm_b;
  logic [4:0]    f3_dec;
  kind_t         dec_kind;
  logic          dec_illegal;
  logic [3:0]    dec_alu;
  logic [31:0]   dec_imm;
  logic          timeout_hit;

  // {valid, op} for the funct3 values shared by R-type and I-type ALU ops
  function automatic logic [4:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_alu = {1'b1, ALU_ADD};
      3'b111:  f3_alu = {1'b1, ALU_AND};
      3'b110:  f3_alu = {1'b1, ALU_OR};
      3'b100:  f3_alu = {1'b1, ALU_XOR};
      3'b010:  f3_alu = {1'b1, ALU_SLT};
      default: f3_alu = {1'b0, ALU_AND};
    endcase
  endfunction

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign f3_dec = f3_alu(funct3);

  always_comb begin
    dec_kind    = K_R;
    dec_illegal = 1'b0;
    dec_alu     = ALU_ADD;
    dec_imm     = '0;
    case (opcode)
      OP_R: begin
        dec_kind = K_R;
        if (funct7 == 7'b0100000 && funct3 == 3'b000) dec_alu = ALU_SUB;
        else if (funct7 == 7'b0000000 && f3_dec[4])   dec_alu = f3_dec[3:0];
        else                                          dec_illegal = 1'b1;
      end
      OP_I: begin
        dec_kind = K_I;
        dec_imm  = imm_i;
        if (f3_dec[4]) dec_alu = f3_dec[3:0];
        else           dec_illegal = 1'b1;
      end
      OP_LW: begin
        dec_kind    = K_LW;
        dec_imm     = imm_i;
        dec_illegal = (funct3 != 3'b010);
      end
      OP_SW: begin
        dec_kind    = K_SW;
        dec_imm     = imm_s;
        dec_illegal = (funct3 != 3'b010);
      end
      OP_BEQ: begin
        dec_kind    = K_BEQ;
        dec_imm     = imm_b;
        dec_alu     = ALU_SUB;
        dec_illegal = (funct3 != 3'b000);
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Request follows run_i in FETCH, but once raised it stays up until acked
  assign instr_req_o  = (state_q == S_FETCH) && (run_i || hold_q);
  assign instr_addr_o = pc_q;
  assign pc_o         = pc_q;
  assign timeout_hit  = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= S_FETCH;
      kind_q            <= K_R;
      pc_q              <= RESET_PC;
      ir_q              <= '0;
      wait_cnt          <= '0;
      hold_q            <= 1'b0;
      read_reg_num1     <= '0;
      read_reg_num2     <= '0;
      write_reg         <= '0;
      alu_control       <= ALU_AND;
      regwrite          <= 1'b0;
      immediate_value_o <= '0;
      alu_src_b_o       <= 1'b0;
      mem_read_o        <= 1'b0;
      mem_write_o       <= 1'b0;
      mem_to_reg_o      <= 1'b0;
      halted_o          <= 1'b0;
      err_code_o        <= 2'b00;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (instr_req_o) begin
            if (instr_ack_i) begin
              ir_q    <= instr_rdata_i;
              hold_q  <= 1'b0;
              state_q <= S_DECODE;
            end else if (timeout_hit) begin
              hold_q     <= 1'b0;
              halted_o   <= 1'b1;
              err_code_o <= 2'b10;
              state_q    <= S_TRAP;
            end else begin
              hold_q <= 1'b1;
              if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            halted_o   <= 1'b1;
            err_code_o <= 2'b01;
            state_q    <= S_TRAP;
          end else begin
            kind_q            <= dec_kind;
            read_reg_num1     <= ir_q[19:15];
            read_reg_num2     <= ir_q[24:20];
            write_reg         <= ir_q[11:7];
            alu_control       <= dec_alu;
            immediate_value_o <= dec_imm;
            regwrite          <= (dec_kind == K_R) || (dec_kind == K_I);
            alu_src_b_o       <= (dec_kind == K_I) || (dec_kind == K_LW) || (dec_kind == K_SW);
            state_q           <= S_EXEC;
          end
        end
        S_EXEC: begin
          regwrite <= 1'b0;
          wait_cnt <= '0;
          case (kind_q)
            K_LW: begin
              mem_read_o   <= 1'b1;
              mem_to_reg_o <= 1'b1;
              regwrite     <= 1'b1;
              state_q      <= S_MEM;
            end
            K_SW: begin
              mem_write_o <= 1'b1;
              state_q     <= S_MEM;
            end
            K_BEQ: begin
              pc_q        <= zero_flag ? pc_q + immediate_value_o : pc_q + 32'd4;
              alu_src_b_o <= 1'b0;
              state_q     <= S_FETCH;
            end
            default: begin
              pc_q        <= pc_q + 32'd4;
              alu_src_b_o <= 1'b0;
              state_q     <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ack_i) begin
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
            regwrite     <= 1'b0;
            alu_src_b_o  <= 1'b0;
            pc_q         <= pc_q + 32'd4;
            wait_cnt     <= '0;
            state_q      <= S_FETCH;
          end else if (timeout_hit) begin
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
            regwrite     <= 1'b0;
            alu_src_b_o  <= 1'b0;
            halted_o     <= 1'b1;
            err_code_o   <= 2'b11;
            state_q      <= S_TRAP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: acts as instruction/data memory responder and checks control
// outputs cycle by cycle against an instruction-level model built from mnemonic tables.
module tb_multicycle_ctrl;

  localparam int          TO    = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          K_R   = 0;
  localparam int          K_I   = 1;
  localparam int          K_LW  = 2;
  localparam int          K_SW  = 3;
  localparam int          K_BEQ = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run_i = 1'b0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_ack_i = 1'b0;
  logic        zero_flag = 1'b0;
  logic        mem_ack_i = 1'b0;
  logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
  logic [3:0]  alu_control;
  logic        regwrite;
  logic [31:0] immediate_value_o;
  logic        alu_src_b_o, mem_read_o, mem_write_o, mem_to_reg_o;
  logic [31:0] pc_o;
  logic        halted_o;
  logic [1:0]  err_code_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] pc_m;

  multicycle_ctrl #(.RESET_PC(RPC), .TIMEOUT(TO), .TW(8)) dut (
    .clock(clock), .reset(reset), .run_i(run_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_rdata_i(instr_rdata_i), .instr_ack_i(instr_ack_i),
    .zero_flag(zero_flag), .mem_ack_i(mem_ack_i),
    .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2), .write_reg(write_reg),
    .alu_control(alu_control), .regwrite(regwrite), .immediate_value_o(immediate_value_o),
    .alu_src_b_o(alu_src_b_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .pc_o(pc_o), .halted_o(halted_o), .err_code_o(err_code_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Mnemonic table: kind, opcode, funct3, funct7, expected ALU op
  function automatic void op_info(input int idx, output int kind, output logic [6:0] opc,
                                  output logic [2:0] f3, output logic [6:0] f7, output logic [3:0] alu);
    f7 = 7'h00;
    case (idx)
      0:  begin kind = K_R;   opc = 7'b0110011; f3 = 3'b000; alu = 4'b0010; end
      1:  begin kind = K_R;   opc = 7'b0110011; f3 = 3'b000; alu = 4'b0100; f7 = 7'h20; end
      2:  begin kind = K_R;   opc = 7'b0110011; f3 = 3'b111; alu = 4'b0000; end
      3:  begin kind = K_R;   opc = 7'b0110011; f3 = 3'b110; alu = 4'b0001; end
      4:  begin kind = K_R;   opc = 7'b0110011; f3 = 3'b100; alu = 4'b0011; end
      5:  begin kind = K_R;   opc = 7'b0110011; f3 = 3'b010; alu = 4'b1000; end
      6:  begin kind = K_I;   opc = 7'b0010011; f3 = 3'b000; alu = 4'b0010; end
      7:  begin kind = K_I;   opc = 7'b0010011; f3 = 3'b111; alu = 4'b0000; end
      8:  begin kind = K_I;   opc = 7'b0010011; f3 = 3'b110; alu = 4'b0001; end
      9:  begin kind = K_I;   opc = 7'b0010011; f3 = 3'b100; alu = 4'b0011; end
      10: begin kind = K_I;   opc = 7'b0010011; f3 = 3'b010; alu = 4'b1000; end
      11: begin kind = K_LW;  opc = 7'b0000011; f3 = 3'b010; alu = 4'b0010; end
      12: begin kind = K_SW;  opc = 7'b0100011; f3 = 3'b010; alu = 4'b0010; end
      default: begin kind = K_BEQ; opc = 7'b1100011; f3 = 3'b000; alu = 4'b0100; end
    endcase
  endfunction

  task automatic gen_random(output logic [31:0] ins, output int kind, output logic [3:0] alu,
                            output logic [31:0] imm);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;
    int iv;
    op_info(int'($urandom_range(0, 13)), kind, opc, f3, f7, alu);
    rs1 = 5'($urandom()); rs2 = 5'($urandom()); rd = 5'($urandom());
    iv  = int'($urandom_range(0, 4095)) - 2048;
    if (kind == K_BEQ) iv = iv * 2;
    imm = iv;
    case (kind)
      K_R:   begin ins = {f7, rs2, rs1, f3, rd, opc}; imm = '0; end
      K_SW:  ins = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      K_BEQ: ins = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      default: ins = {imm[11:0], rs1, f3, rd, opc};
    endcase
  endtask

  task automatic apply_reset();
    run_i = 1'b0; instr_ack_i = 1'b0; mem_ack_i = 1'b0; zero_flag = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    pc_m = RPC;
  endtask

  // Runs one instruction from the first FETCH cycle; mem_abort leaves it after md ack-less MEM cycles.
  task automatic run_instr(input logic [31:0] ins, input int kind, input logic [3:0] alu_e,
                           input logic [31:0] imm_e, input logic legal, input int fd, input int md,
                           input logic zf, input logic mem_abort, output int exec_cyc);
    logic exp_rw, exp_sb, is_lw;
    exec_cyc = -1;
    run_i = 1'b1;
    instr_rdata_i = ins;
    for (int i = 0; i <= fd; i++) begin
      instr_ack_i = (i == fd);
      #1;
      n_cmp++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== pc_m || pc_o !== pc_m) begin
        n_bad++;
        $display("FAIL fetch: req=%b addr=%h pc=%h, required req=1 addr=pc=%h", instr_req_o, instr_addr_o, pc_o, pc_m);
      end
      n_cmp++;
      if ({regwrite, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_b_o, halted_o} !== 6'b0) begin
        n_bad++;
        $display("FAIL fetch_strobes: rw/mr/mw/m2r/srcb/halt=%b%b%b%b%b%b, required all 0",
                 regwrite, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_b_o, halted_o);
      end
      @(negedge clock);
    end
    instr_ack_i = 1'b0;
    instr_rdata_i = $urandom();
    #1;
    n_cmp++;
    if ({regwrite, mem_read_o, mem_write_o, halted_o, instr_req_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL decode_quiet: rw/mr/mw/halt/req=%b%b%b%b%b, required all 0",
               regwrite, mem_read_o, mem_write_o, halted_o, instr_req_o);
    end
    @(negedge clock);
    if (!legal) begin
      #1;
      n_cmp++;
      if (halted_o !== 1'b1 || err_code_o !== 2'b01 || instr_req_o !== 1'b0 || regwrite !== 1'b0) begin
        n_bad++;
        $display("FAIL illegal_trap: halted=%b err=%b req=%b rw=%b, required 1/01/0/0", halted_o, err_code_o, instr_req_o, regwrite);
      end
      return;
    end
    zero_flag = zf;
    #1;
    exec_cyc = cyc;
    exp_rw = (kind == K_R) || (kind == K_I);
    exp_sb = (kind == K_I) || (kind == K_LW) || (kind == K_SW);
    n_cmp++;
    if (regwrite !== exp_rw || alu_src_b_o !== exp_sb || alu_control !== alu_e || mem_read_o !== 1'b0 || mem_write_o !== 1'b0) begin
      n_bad++;
      $display("FAIL exec_ctrl: ins=%h rw=%b srcb=%b alu=%b mr=%b mw=%b, required rw=%b srcb=%b alu=%b mr=0 mw=0",
               ins, regwrite, alu_src_b_o, alu_control, mem_read_o, mem_write_o, exp_rw, exp_sb, alu_e);
    end
    n_cmp++;
    if (read_reg_num1 !== ins[19:15] || read_reg_num2 !== ins[24:20] || write_reg !== ins[11:7]) begin
      n_bad++;
      $display("FAIL exec_regs: ins=%h rs1=%0d rs2=%0d rd=%0d, required %0d %0d %0d",
               ins, read_reg_num1, read_reg_num2, write_reg, ins[19:15], ins[24:20], ins[11:7]);
    end
    if (kind != K_R) begin
      n_cmp++;
      if (immediate_value_o !== imm_e) begin
        n_bad++;
        $display("FAIL exec_imm: ins=%h imm=%h, required %h", ins, immediate_value_o, imm_e);
      end
    end
    @(negedge clock);
    zero_flag = 1'($urandom());
    if (kind == K_LW || kind == K_SW) begin
      is_lw = (kind == K_LW);
      for (int j = 0; j <= md; j++) begin
        if (mem_abort && j == md) return;
        mem_ack_i = (j == md) && !mem_abort;
        #1;
        n_cmp++;
        if (mem_read_o !== is_lw || mem_to_reg_o !== is_lw || regwrite !== is_lw || mem_write_o !== !is_lw || halted_o !== 1'b0) begin
          n_bad++;
          $display("FAIL mem_strobes: ins=%h cyc%0d mr=%b m2r=%b rw=%b mw=%b halt=%b, required mr=m2r=rw=%b mw=%b halt=0",
                   ins, j, mem_read_o, mem_to_reg_o, regwrite, mem_write_o, halted_o, is_lw, !is_lw);
        end
        @(negedge clock);
        mem_ack_i = 1'b0;
      end
    end
    pc_m = (kind == K_BEQ && zf) ? pc_m + imm_e : pc_m + 32'd4;
    #1;
    n_cmp++;
    if (pc_o !== pc_m || {regwrite, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_b_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL retire: ins=%h pc=%h strobes=%b%b%b%b%b, required pc=%h strobes=00000",
               ins, pc_o, regwrite, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_b_o, pc_m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run_i = 1'b0;
    @(negedge clock);
    #1;
    n_cmp++;
    if (pc_o !== RPC || halted_o !== 1'b0 || err_code_o !== 2'b00 || instr_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: pc=%h halt=%b err=%b req=%b, required %h 0 00 0", pc_o, halted_o, err_code_o, instr_req_o, RPC);
    end
    n_cmp++;
    if ({regwrite, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_b_o} !== 5'b0 || alu_control !== 4'b0000 ||
        immediate_value_o !== 32'h0 || {read_reg_num1, read_reg_num2, write_reg} !== 15'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: strobes=%b%b%b%b%b alu=%b imm=%h regs=%0d/%0d/%0d, required all 0",
               regwrite, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_b_o, alu_control, immediate_value_o,
               read_reg_num1, read_reg_num2, write_reg);
    end
    apply_reset();
    @(negedge clock);
    run_i = 1'b1;
    #1;
    n_cmp++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== RPC) begin
      n_bad++;
      $display("FAIL reset_fetch: req=%b addr=%h, required 1 %h", instr_req_o, instr_addr_o, RPC);
    end
    run_i = 1'b0;
  endtask

  task automatic test_alu_pair();
    int s, e1, e2;
    apply_reset();
    s = cyc;
    run_instr(32'h00500093, K_I, 4'b0010, 32'd5, 1'b1, 0, 0, 1'b0, 1'b0, e1);
    run_instr(32'h001081B3, K_R, 4'b0010, 32'd0, 1'b1, 0, 0, 1'b0, 1'b0, e2);
    n_cmp++;
    if (e1 - s != 2 || e2 - e1 != 3 || pc_o !== 32'd8) begin
      n_bad++;
      $display("FAIL alu_pair_timing: rw cycles %0d,%0d pc=%h, required cycles 3,6 pc=00000008", e1 - s + 1, e2 - s + 1, pc_o);
    end
  endtask

  task automatic test_load_store();
    int e;
    apply_reset();
    run_instr(32'h0080A283, K_LW, 4'b0010, 32'd8, 1'b1, 0, 3, 1'b0, 1'b0, e);
    run_instr(32'h0050A623, K_SW, 4'b0010, 32'd12, 1'b1, 1, 2, 1'b0, 1'b0, e);
  endtask

  task automatic test_branch();
    int e;
    apply_reset();
    for (int i = 0; i < 8; i++) run_instr(32'h00000013, K_I, 4'b0010, 32'd0, 1'b1, 0, 0, 1'b0, 1'b0, e);
    run_instr(32'hFE000CE3, K_BEQ, 4'b0100, 32'hFFFF_FFF8, 1'b1, 0, 0, 1'b1, 1'b0, e);
    n_cmp++;
    if (pc_o !== 32'h18) begin
      n_bad++;
      $display("FAIL beq_taken: pc=%h, required 00000018", pc_o);
    end
    for (int i = 0; i < 2; i++) run_instr(32'h00000013, K_I, 4'b0010, 32'd0, 1'b1, 0, 0, 1'b0, 1'b0, e);
    run_instr(32'hFE000CE3, K_BEQ, 4'b0100, 32'hFFFF_FFF8, 1'b1, 0, 0, 1'b0, 1'b0, e);
    n_cmp++;
    if (pc_o !== 32'h24) begin
      n_bad++;
      $display("FAIL beq_not_taken: pc=%h, required 00000024", pc_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins, imm;
    logic [3:0]  alu;
    int          kind, e;
    apply_reset();
    for (int n = 0; n < 200; n++) begin
      gen_random(ins, kind, alu, imm);
      run_instr(ins, kind, alu, imm, 1'b1, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
                1'($urandom()), 1'b0, e);
    end
  endtask

  task automatic test_run_gating();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      instr_ack_i = 1'b1; instr_rdata_i = 32'h0000007F;
      #1;
      n_cmp++;
      if (instr_req_o !== 1'b0) begin
        n_bad++;
        $display("FAIL run_low_req: req=%b, required 0", instr_req_o);
      end
      @(negedge clock);
    end
    instr_ack_i = 1'b0;
    #1;
    n_cmp++;
    if (halted_o !== 1'b0 || pc_o !== RPC) begin
      n_bad++;
      $display("FAIL ack_ignored: halt=%b pc=%h, required 0 %h", halted_o, pc_o, RPC);
    end
    run_i = 1'b1; instr_rdata_i = 32'h00700113;
    @(negedge clock);
    run_i = 1'b0;
    #1;
    n_cmp++;
    if (instr_req_o !== 1'b1) begin
      n_bad++;
      $display("FAIL req_held: req=%b after run_i drop, required 1", instr_req_o);
    end
    @(negedge clock);
    instr_ack_i = 1'b1;
    @(negedge clock);
    instr_ack_i = 1'b0;
    @(negedge clock);
    #1;
    n_cmp++;
    if (regwrite !== 1'b1 || write_reg !== 5'd2 || immediate_value_o !== 32'd7) begin
      n_bad++;
      $display("FAIL inflight_completes: rw=%b rd=%0d imm=%h, required 1 2 00000007", regwrite, write_reg, immediate_value_o);
    end
    @(negedge clock);
    @(negedge clock);
    #1;
    n_cmp++;
    if (instr_req_o !== 1'b0 || pc_o !== RPC + 32'd4 || regwrite !== 1'b0) begin
      n_bad++;
      $display("FAIL run_low_idle: req=%b pc=%h rw=%b, required 0 %h 0", instr_req_o, pc_o, regwrite, RPC + 32'd4);
    end
  endtask

  task automatic test_illegal();
    int e;
    apply_reset();
    run_instr(32'h0000007F, K_R, 4'b0000, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, e);
    run_i = 1'b1; instr_ack_i = 1'b1;
    repeat (3) @(negedge clock);
    instr_ack_i = 1'b0;
    #1;
    n_cmp++;
    if (halted_o !== 1'b1 || err_code_o !== 2'b01 || instr_req_o !== 1'b0 || pc_o !== RPC) begin
      n_bad++;
      $display("FAIL trap_sticky: halt=%b err=%b req=%b pc=%h, required 1 01 0 %h", halted_o, err_code_o, instr_req_o, pc_o, RPC);
    end
    apply_reset();
    run_instr(32'h00001013, K_I, 4'b0000, 32'd0, 1'b0, 1, 0, 1'b0, 1'b0, e);
    apply_reset();
    run_instr(32'h02000033, K_R, 4'b0000, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, e);
  endtask

  task automatic test_timeout();
    int e;
    apply_reset();
    run_i = 1'b1;
    for (int i = 0; i < TO; i++) begin
      #1;
      n_cmp++;
      if (instr_req_o !== 1'b1 || halted_o !== 1'b0) begin
        n_bad++;
        $display("FAIL fetch_wait: wait%0d req=%b halt=%b, required 1 0", i, instr_req_o, halted_o);
      end
      @(negedge clock);
    end
    #1;
    n_cmp++;
    if (halted_o !== 1'b1 || err_code_o !== 2'b10 || instr_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_timeout: halt=%b err=%b req=%b, required 1 10 0", halted_o, err_code_o, instr_req_o);
    end
    apply_reset();
    run_instr(32'h00500093, K_I, 4'b0010, 32'd5, 1'b1, TO - 1, 0, 1'b0, 1'b0, e);
    n_cmp++;
    if (halted_o !== 1'b0 || err_code_o !== 2'b00) begin
      n_bad++;
      $display("FAIL ack_at_limit: halt=%b err=%b, required 0 00", halted_o, err_code_o);
    end
    run_instr(32'h0080A283, K_LW, 4'b0010, 32'd8, 1'b1, 0, TO, 1'b0, 1'b1, e);
    #1;
    n_cmp++;
    if (halted_o !== 1'b1 || err_code_o !== 2'b11 || {regwrite, mem_read_o, mem_to_reg_o, mem_write_o} !== 4'b0) begin
      n_bad++;
      $display("FAIL mem_timeout: halt=%b err=%b strobes=%b%b%b%b, required 1 11 0000",
               halted_o, err_code_o, regwrite, mem_read_o, mem_to_reg_o, mem_write_o);
    end
  endtask

  task automatic test_reset_mid_mem();
    int e;
    apply_reset();
    run_instr(32'h00500093, K_I, 4'b0010, 32'd5, 1'b1, 0, 0, 1'b0, 1'b0, e);
    run_instr(32'h0080A283, K_LW, 4'b0010, 32'd8, 1'b1, 0, 2, 1'b0, 1'b1, e);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({regwrite, mem_read_o, mem_to_reg_o, mem_write_o} !== 4'b0 || pc_o !== RPC || halted_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_mem: strobes=%b%b%b%b pc=%h halt=%b, required 0000 %h 0",
               regwrite, mem_read_o, mem_to_reg_o, mem_write_o, pc_o, halted_o, RPC);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_pair();
    test_load_store();
    test_branch();
    test_run_gating();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer that fetches, decodes and steps instructions through the register-file/ALU/memory datapath.
- Drives every datapath control input: register numbers, alu_control, regwrite, immediate, operand-B select, memory read/write, mem-to-reg.
- Owns the PC and the instruction-fetch handshake; takes zero_flag and mem_ack back from the datapath/bus.
- Supports an RV32I subset: R-type ALU, I-type ALU, LW, SW, BEQ.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max wait cycles for instr_ack_i/mem_ack_i before trapping; 0 disables the timeout
TW, 8, width of the wait counter; must satisfy TIMEOUT < 2^TW

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run_i  in  1  when low, no new fetch starts
instr_req_o  out  1  instruction fetch request
instr_addr_o  out  32  fetch address (= PC)
instr_rdata_i  in  32  instruction word, valid with ack
instr_ack_i  in  1  fetch acknowledge
zero_flag  in  1  ALU zero from datapath
mem_ack_i  in  1  data-memory acknowledge
read_reg_num1  out  5  rs1
read_reg_num2  out  5  rs2
write_reg  out  5  rd
alu_control  out  4  ALU op
regwrite  out  1  register write request
immediate_value_o  out  32  sign-extended immediate
alu_src_b_o  out  1  1 = immediate as ALU operand B
mem_read_o  out  1  load strobe
mem_write_o  out  1  store strobe
mem_to_reg_o  out  1  writeback from memory
pc_o  out  32  current PC
halted_o  out  1  trap reached
err_code_o  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 memory timeout

Behaviour:
- Reset (async assert, sync release): state=FETCH, PC=RESET_PC, IR=0, wait counter=0, err=00, halted_o=0. All strobes 0, all register numbers 0, immediate 0, alu_control=0000.
- alu_control encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0100, SLT 1000. Unsupported funct3/funct7 decodes as illegal.
- FETCH:
  - instr_req_o = run_i.
  - Same-cycle ack is allowed. On instr_req_o & instr_ack_i: IR <= instr_rdata_i, go to DECODE.
  - The request is held until ack.
  - Ack while instr_req_o=0 is ignored.
- DECODE (1 cycle):
  - Register rs1, rs2, rd, immediate (I/S/B formats, sign-extended) and alu_control.
  - Opcodes: 0110011 R, 0010011 I, 0000011 LW, 0100011 SW, 1100011 BEQ.
  - Any other opcode -> TRAP, err=01.
- EXEC (1 cycle):
  - R/I: regwrite=1 for exactly this cycle, alu_src_b_o=1 for I. PC += 4, go to FETCH.
  - BEQ: alu_control=SUB, regwrite=0. Sample zero_flag this cycle: PC = zero_flag ? PC+imm : PC+4 (32-bit wrap). Go to FETCH.
  - LW/SW: alu_control=ADD, alu_src_b_o=1, go to MEM.
- MEM:
  - LW: mem_read_o=1, mem_to_reg_o=1 and regwrite=1, all held every cycle until mem_ack_i. The datapath commits the write only on the ack cycle.
  - SW: mem_write_o=1, held until mem_ack_i.
  - On ack: all strobes drop next cycle, PC += 4, go to FETCH.
- Latency with zero-wait acks: R/I/BEQ = 3 cycles per instruction; LW/SW = 4 cycles.
- Wait counter:
  - Clears on entry to FETCH or MEM; increments each cycle without ack.
  - With TIMEOUT != 0, reaching TIMEOUT without ack -> TRAP, err=10 (fetch) or 11 (MEM).
  - An ack in the same cycle the count hits TIMEOUT wins; no trap.
- TRAP: all strobes 0, halted_o=1, err_code_o held. Exit only by reset.
- run_i low:
  - Takes effect only at FETCH entry; an in-flight instruction completes.
  - If deasserted while a request is pending, the request is still held to ack.
- Outputs are registered.
- rd=x0 writes are issued unchanged; the datapath ignores them.

Test Plan:
- Reset mid-MEM (LW waiting on ack) -> all strobes 0 immediately, pc_o=RESET_PC, halted_o=0.
- ADDI x1,x0,5 (0x00500093) then ADD x3,x1,x1 (0x001081B3), zero-wait acks -> regwrite pulses in cycles 3 and 6; write_reg=1 then 3; alu_src_b_o 1 then 0; pc_o=8.
- LW x5,8(x1) (0x0080A283), mem_ack_i delayed 3 cycles -> mem_read_o/regwrite/mem_to_reg_o high 4 cycles, immediate_value_o=8, drop after ack, PC+4.
- SW x5,12(x1) (0x0050A623) -> mem_write_o held until ack, regwrite stays 0, immediate_value_o=12.
- BEQ x0,x0,-8 (0xFE000CE3) at PC=0x20, zero_flag=1 -> pc_o=0x18. Repeat with zero_flag=0 -> pc_o=0x24.
- Opcode 0x0000007F -> halted_o=1, err=01. Separately, TIMEOUT=4 with no instr_ack_i -> trap after 4 wait cycles, err=10. Ack arriving on the 4th wait cycle -> no trap.
